// File: rtl/maze_move_ctrl_if.sv
// Keyboard command and wall-map port bundle for maze_move_ctrl.
// slave is the controller side; master is the keyboard/memory side.
interface maze_move_ctrl_if #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
);
  logic                     signal;
  logic [1:0]               data;
  logic [X_BITS+Y_BITS-1:0] map_addr;
  logic                     map_rd_en;
  logic                     map_rd_data;

  modport slave (
    input  signal,
    input  data,
    input  map_rd_data,
    output map_addr,
    output map_rd_en
  );

  modport master (
    output signal,
    output data,
    output map_rd_data,
    input  map_addr,
    input  map_rd_en
  );
endinterface

// File: rtl/maze_move_ctrl.sv
// Player motion controller: turns keyboard direction strobes into maze moves,
// checking walls through a one-cycle-latency map read.
module maze_move_ctrl #(
  parameter int X_BITS    = 4,
  parameter int Y_BITS    = 4,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int START_DIR = 0,
  parameter int GOAL_X    = 15,
  parameter int GOAL_Y    = 15
) (
  input  logic              clk,
  input  logic              rst,
  maze_move_ctrl_if.slave   bus,
  output logic [X_BITS-1:0] pos_x,
  output logic [Y_BITS-1:0] pos_y,
  output logic [1:0]        heading,
  output logic [15:0]       move_cnt,
  output logic              busy,
  output logic              bump,
  output logic              goal
);

  localparam int AW = X_BITS + Y_BITS;
  localparam logic [X_BITS-1:0] SX = X_BITS'(START_X);
  localparam logic [Y_BITS-1:0] SY = Y_BITS'(START_Y);
  localparam logic [1:0]        SD = 2'(START_DIR);
  localparam logic [X_BITS-1:0] GX = X_BITS'(GOAL_X);
  localparam logic [Y_BITS-1:0] GY = Y_BITS'(GOAL_Y);
  localparam logic [X_BITS:0]   X1 = (X_BITS+1)'(1);
  localparam logic [Y_BITS:0]   Y1 = (Y_BITS+1)'(1);
  localparam logic AT_GOAL = (SX == GX) && (SY == GY);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CHECK,
    DONE
  } state_t;

  state_t state, state_n;

  logic              sig_q;
  logic              cmd;
  logic [X_BITS-1:0] tx, tx_n, x_n;
  logic [Y_BITS-1:0] ty, ty_n, y_n;
  logic [1:0]        hd_n;
  logic [15:0]       cnt_n;
  logic              bump_n, goal_n, rd_n;
  logic [AW-1:0]     addr_n;
  logic [X_BITS:0]   ex;
  logic [Y_BITS:0]   ey;
  logic              oob;

  assign cmd  = bus.signal & ~sig_q;
  assign busy = (state == FETCH) || (state == CHECK);

  // One extra bit catches both underflow and overflow past the maze edge.
  always_comb begin
    ex = {1'b0, pos_x};
    ey = {1'b0, pos_y};
    unique case (heading)
      2'd0: ey = ey - Y1;
      2'd1: ex = ex + X1;
      2'd2: ey = ey + Y1;
      2'd3: ex = ex - X1;
      default: ;
    endcase
    oob = ex[X_BITS] | ey[Y_BITS];
  end

  always_comb begin
    state_n = state;
    x_n     = pos_x;
    y_n     = pos_y;
    hd_n    = heading;
    cnt_n   = move_cnt;
    goal_n  = goal;
    bump_n  = 1'b0;
    rd_n    = 1'b0;
    addr_n  = bus.map_addr;
    tx_n    = tx;
    ty_n    = ty;
    unique case (state)
      IDLE: begin
        if (cmd && !goal) begin
          unique case (1'b1)
            (bus.data == 2'd2): hd_n = heading - 2'd1;
            (bus.data == 2'd3): hd_n = heading + 2'd1;
            (bus.data == 2'd1): begin
              if (oob) begin
                bump_n = 1'b1;
              end else begin
                tx_n    = ex[X_BITS-1:0];
                ty_n    = ey[Y_BITS-1:0];
                addr_n  = {ey[Y_BITS-1:0], ex[X_BITS-1:0]};
                rd_n    = 1'b1;
                state_n = FETCH;
              end
            end
            default: ;
          endcase
        end
      end
      FETCH: state_n = CHECK;
      CHECK: begin
        if (bus.map_rd_data) begin
          bump_n  = 1'b1;
          state_n = IDLE;
        end else begin
          x_n = tx;
          y_n = ty;
          if (move_cnt != 16'hFFFF)
            cnt_n = move_cnt + 16'd1;
          if (tx == GX && ty == GY) begin
            goal_n  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= AT_GOAL ? DONE : IDLE;
      sig_q         <= 1'b0;
      pos_x         <= SX;
      pos_y         <= SY;
      heading       <= SD;
      move_cnt      <= 16'd0;
      goal          <= AT_GOAL;
      bump          <= 1'b0;
      bus.map_rd_en <= 1'b0;
      bus.map_addr  <= '0;
      tx            <= '0;
      ty            <= '0;
    end else begin
      state         <= state_n;
      sig_q         <= bus.signal;
      pos_x         <= x_n;
      pos_y         <= y_n;
      heading       <= hd_n;
      move_cnt      <= cnt_n;
      goal          <= goal_n;
      bump          <= bump_n;
      bus.map_rd_en <= rd_n;
      bus.map_addr  <= addr_n;
      tx            <= tx_n;
      ty            <= ty_n;
    end
  end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Scoreboard bench for maze_move_ctrl: a cycle-stamped maze model predicts
// each command's outcome; a negedge monitor compares against the DUT.
module tb_maze_move_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  maze_move_ctrl_if #(.X_BITS(4), .Y_BITS(4)) bus_if ();

  logic [3:0]  pos_x;
  logic [3:0]  pos_y;
  logic [1:0]  heading;
  logic [15:0] move_cnt;
  logic        busy;
  logic        bump;
  logic        goal;

  maze_move_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .heading  (heading),
    .move_cnt (move_cnt),
    .busy     (busy),
    .bump     (bump),
    .goal     (goal)
  );

  bit wall [256];

  always @(posedge clk)
    if (bus_if.map_rd_en === 1'b1)
      bus_if.map_rd_data <= wall[bus_if.map_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int x;
    int y;
    int dir;
    int cnt;
    bit gl;
    bit bsy;
    bit chk_addr;
    int addr;
  } exp_t;

  exp_t q[$];
  bit   bump_at [int];
  bit   rd_at [int];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  int mx, my, md, mc, ready;
  bit mg;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0d want %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void push(int c, bit bsy, bit chk_addr, int addr);
    exp_t e;
    e.cyc = c;
    e.x = mx;
    e.y = my;
    e.dir = md;
    e.cnt = mc;
    e.gl = mg;
    e.bsy = bsy;
    e.chk_addr = chk_addr;
    e.addr = addr;
    q.push_back(e);
  endfunction

  function automatic void model_cmd(int code, int t);
    int nx, ny, a;
    if (mg || t < ready) begin
      push((t + 1 > ready) ? t + 1 : ready, 1'b0, 1'b0, 0);
      return;
    end
    case (code)
      2: begin md = (md + 3) % 4; push(t + 1, 1'b0, 1'b0, 0); end
      3: begin md = (md + 1) % 4; push(t + 1, 1'b0, 1'b0, 0); end
      1: begin
        nx = mx;
        ny = my;
        case (md)
          0: ny = ny - 1;
          1: nx = nx + 1;
          2: ny = ny + 1;
          default: nx = nx - 1;
        endcase
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
          bump_at[t + 1] = 1'b1;
          push(t + 1, 1'b0, 1'b0, 0);
        end else begin
          a = ny * 16 + nx;
          rd_at[t + 1] = 1'b1;
          push(t + 1, 1'b1, 1'b1, a);
          if (wall[a]) begin
            bump_at[t + 3] = 1'b1;
          end else begin
            mx = nx;
            my = ny;
            if (mc < 65535) mc++;
            if (nx == 15 && ny == 15) mg = 1'b1;
          end
          push(t + 3, 1'b0, 1'b0, 0);
          ready = t + 3;
        end
      end
      default: push(t + 1, 1'b0, 1'b0, 0);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      check("bump", bump, bump_at.exists(cyc));
      check("rd_en", bus_if.map_rd_en, rd_at.exists(cyc));
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check("when", cyc, e.cyc);
        check("pos_x", pos_x, e.x);
        check("pos_y", pos_y, e.y);
        check("heading", heading, e.dir);
        check("move_cnt", move_cnt, e.cnt);
        check("goal", goal, e.gl);
        check("busy", busy, e.bsy);
        if (e.chk_addr) check("map_addr", bus_if.map_addr, e.addr);
      end
    end
  end

  task automatic do_reset(int n);
    int r0;
    @(posedge clk);
    #1;
    r0 = cyc;
    rst = 1'b1;
    bus_if.signal = 1'b0;
    bus_if.data = 2'd0;
    while (q.size() > 0 && q[$].cyc > r0) void'(q.pop_back());
    for (int k = r0 + 1; k <= r0 + 4; k++) begin
      bump_at.delete(k);
      rd_at.delete(k);
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    mx = 0; my = 0; md = 0; mc = 0; mg = 1'b0;
    ready = cyc;
    push(cyc, 1'b0, 1'b1, 0);
    mon_on = 1'b1;
  endtask

  task automatic press(int code, int hold, int low);
    @(posedge clk);
    #1;
    bus_if.signal = 1'b1;
    bus_if.data = 2'(code);
    model_cmd(code, cyc);
    repeat (hold - 1) begin
      @(posedge clk);
      #1;
      bus_if.data = 2'($urandom);
    end
    @(posedge clk);
    #1;
    bus_if.signal = 1'b0;
    repeat (low - 1) @(posedge clk);
  endtask

  task automatic wait_ready();
    while (cyc < ready) @(posedge clk);
  endtask

  task automatic go(int code);
    wait_ready();
    press(code, 2, 1);
  endtask

  initial begin
    int b;
    bus_if.signal = 1'b0;
    bus_if.data = 2'd0;
    do_reset(3);

    go(1);
    go(3); go(3); go(2); go(3);
    wall[16] = 1'b1;
    go(1);
    wait_ready();
    wall[16] = 1'b0;
    go(1);

    wait_ready();
    press(3, 1000, 1);
    go(2);
    wait_ready();
    press(1, 1, 1);
    press(3, 1, 1);

    wait_ready();
    for (int i = 0; i < 256; i++) wall[i] = ($urandom_range(0, 3) == 0);
    wall[0] = 1'b0;
    repeat (200)
      press($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(1, 3));

    do_reset(2);
    for (int i = 0; i < 256; i++) wall[i] = 1'b0;
    go(3); go(3);
    repeat (15) go(1);
    go(2);
    repeat (15) go(1);
    wait_ready();
    repeat (6) press($urandom_range(0, 3), 1, 1);

    do_reset(1);
    go(3); go(3);
    wait_ready();
    @(posedge clk);
    #1;
    bus_if.signal = 1'b1;
    bus_if.data = 2'd1;
    model_cmd(1, cyc);
    do_reset(1);
    go(3); go(3); go(1);

    b = 0;
    while (q.size() > 0 && b < 100) begin
      @(posedge clk);
      b++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
